// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared widths, signed limits and FSM state type for the accumulator
// Contents:
//   DATA_W      default operand/sum width
//   SMAX, SMIN  signed 32-bit limits used when a sum clamps
//   state_t     accumulator FSM states {IDLE, ACCUM, HOLD}
package adder_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] SMAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SMIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_sum_accumulator_if.sv
// rtl/stream_sum_accumulator_if.sv - operand input stream and result output stream bundle
// Signals:
//   in_valid/in_ready/in_data/in_last    operand stream (producer -> accumulator)
//   out_valid/out_ready/out_sum/out_cout/out_overflow/out_beats
//                                        result stream (accumulator -> consumer)
// Modports:
//   master  traffic source/sink side (drives operands, accepts results)
//   slave   accumulator side
interface stream_sum_accumulator_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_overflow;
    logic [CNT_W-1:0] out_beats;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_overflow, out_beats
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_overflow, out_beats
    );
endinterface

// File: rtl/acc_add_sat.sv
// rtl/acc_add_sat.sv - combinational WIDTH-bit signed add with carry, overflow and optional clamp
// Ports:
//   a, b   operands (two's complement)
//   sum    a + b, wrapped, or clamped when ACC_SATURATE_EN is defined
//   cout   carry out of bit WIDTH-1 of the raw addition
//   ovf    signed overflow of the raw addition
// Build option: ACC_SATURATE_EN enables clamping to the signed limits.
module acc_add_sat #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] raw_sum;

    assign raw     = {1'b0, a} + {1'b0, b};
    assign raw_sum = raw[WIDTH-1:0];
    assign cout    = raw[WIDTH];
    // Overflow only when both operands share a sign the result does not.
    assign ovf     = (a[WIDTH-1] == b[WIDTH-1]) & (raw_sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow the operands' common sign picks the limit to clamp to.
    assign sum = ovf ? (a[WIDTH-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
    assign sum = raw_sum;
`endif
endmodule

// File: rtl/stream_sum_accumulator.sv
// rtl/stream_sum_accumulator.sv - packet summing accumulator between valid/ready streams
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     stream_sum_accumulator_if.slave: operand stream in, packet result out
// Build option: ACC_SATURATE_EN (in acc_add_sat) clamps overflowing sums.
module stream_sum_accumulator
    import adder_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_sum_accumulator_if.slave  bus
);
    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic             accept_in;
    logic [CNT_W-1:0] count_inc;
    logic             close_pkt;

    // acc is zero whenever the FSM is in IDLE, so the first beat is simply 0 + in_data.
    acc_add_sat #(.WIDTH(WIDTH)) u_add (
        .a    (acc),
        .b    (bus.in_data),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    assign accept_in = bus.in_valid & in_ready_q;
    assign count_inc = count + 1'b1;
    assign close_pkt = bus.in_last | (count_inc == CNT_W'(MAX_BEATS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept_in) begin
                        acc    <= add_sum;
                        count  <= count_inc;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        if (close_pkt) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept_in) begin
                        acc    <= add_sum;
                        count  <= count_inc;
                        cout_q <= add_cout;
                        ovf_q  <= ovf_q | add_ovf;
                        if (close_pkt) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        acc         <= '0;
                        count       <= '0;
                        cout_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = acc;
    assign bus.out_cout     = cout_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_beats    = count;
endmodule
